// File: rtl/l2c_wb_ack_mc_pkg.sv
// -----------------------------------------------------------------------------
// l2c_wb_ack_pkg
// Shared definitions for the multi-channel L2C writeback-ack sequencer:
//   - one-hot sequencer state encodings (Idle / Tag / Broadcast)
//   - default ack-ID width and per-channel FIFO depth
//   - clog2 helper for elaboration-time width sizing
// -----------------------------------------------------------------------------
package l2c_wb_ack_pkg;

  localparam int IDW_DEF   = 6;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_TAG  = 3'b010,
    ST_BC   = 3'b100
  } state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/l2c_wb_ack_mc_if.sv
// -----------------------------------------------------------------------------
// l2c_wb_ack_mc_if
// Bundles the MNI writeback-ack inputs, the tag-pipeline handshake and the
// broadcast/status outputs of l2c_wb_ack_mc.
//   master : environment side (drives acks and i_tag_ack, observes the rest)
//   slave  : sequencer side (l2c_wb_ack_mc)
// Signals:
//   i_mni_wb_ack_valid [NCH]      per-channel ack valid
//   i_mni_wb_ack_id    [NCH*IDW]  per-channel ack ID, channel c at [c*IDW +: IDW]
//   o_mni_wb_ack_stall [NCH]      per-channel stall (FIFO full)
//   o_tag_req / o_tag_id / o_tag_ch, i_tag_ack   tag handshake
//   o_broadcast / o_broadcast_id / o_broadcast_ch one-cycle broadcast
//   o_pending [NCH]               per-channel FIFO non-empty
//   o_tag_timeout                 sticky tag-wait watchdog flag
// -----------------------------------------------------------------------------
interface l2c_wb_ack_mc_if
  import l2c_wb_ack_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IDW = IDW_DEF,
  parameter int CHW = 1
);

  logic [NCH-1:0]     i_mni_wb_ack_valid;
  logic [NCH*IDW-1:0] i_mni_wb_ack_id;
  logic [NCH-1:0]     o_mni_wb_ack_stall;
  logic               o_tag_req;
  logic [IDW-1:0]     o_tag_id;
  logic [CHW-1:0]     o_tag_ch;
  logic               i_tag_ack;
  logic               o_broadcast;
  logic [IDW-1:0]     o_broadcast_id;
  logic [CHW-1:0]     o_broadcast_ch;
  logic [NCH-1:0]     o_pending;
  logic               o_tag_timeout;

  modport master (
    output i_mni_wb_ack_valid, i_mni_wb_ack_id, i_tag_ack,
    input  o_mni_wb_ack_stall, o_tag_req, o_tag_id, o_tag_ch,
           o_broadcast, o_broadcast_id, o_broadcast_ch, o_pending, o_tag_timeout
  );

  modport slave (
    input  i_mni_wb_ack_valid, i_mni_wb_ack_id, i_tag_ack,
    output o_mni_wb_ack_stall, o_tag_req, o_tag_id, o_tag_ch,
           o_broadcast, o_broadcast_id, o_broadcast_ch, o_pending, o_tag_timeout
  );

endinterface

// File: rtl/l2c_wb_ack_fifo.sv
// -----------------------------------------------------------------------------
// l2c_wb_ack_fifo
// Single-channel synchronous FIFO holding pending writeback-ack IDs.
// Ports:
//   Clk, Reset         clock, synchronous active-high reset (empties the FIFO)
//   push_i, push_id_i  write strobe and ID (ignored when full)
//   pop_i              read strobe (ignored when empty)
//   head_o             ID at the head of the queue (valid when !empty_o)
//   full_o, empty_o    status, decoded from the registered occupancy count
// -----------------------------------------------------------------------------
module l2c_wb_ack_fifo
  import l2c_wb_ack_pkg::*;
#(
  parameter int IDW   = IDW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           push_i,
  input  logic [IDW-1:0] push_id_i,
  input  logic           pop_i,
  output logic [IDW-1:0] head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [IDW-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read after it was written, and leaving it reset-free lets it map to RAM/plain flops.
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/l2c_wb_ack_mc.sv
// -----------------------------------------------------------------------------
// l2c_wb_ack_mc
// Multi-channel buffered L2C writeback-ack sequencer. Acks from NCH MNI
// channels are queued in per-channel FIFOs; a round-robin arbiter picks one,
// runs the tag handshake (o_tag_req until i_tag_ack), then issues a one-cycle
// broadcast of the ack ID and channel and pops that FIFO.
// Ports:
//   Clk, Reset   clock, synchronous active-high reset (drops all queued acks)
//   bus          l2c_wb_ack_mc_if.slave (ack inputs, tag handshake, broadcast,
//                pending/stall status, timeout flag)
// Optional feature (macro L2C_WB_ACK_TMO_EN): tag-wait watchdog; sets the
// sticky o_tag_timeout after TMO cycles in Tag. Without the macro the flag
// is tied to 0 and no counter exists.
// -----------------------------------------------------------------------------
module l2c_wb_ack_mc
  import l2c_wb_ack_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int IDW   = IDW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CHW   = (clog2(NCH) < 1) ? 1 : clog2(NCH),
  parameter int TMO   = 255
) (
  input  logic            Clk,
  input  logic            Reset,
  l2c_wb_ack_mc_if.slave  bus
);

  state_e                   state_q;
  logic [CHW-1:0]           rr_q;
  logic [CHW-1:0]           sel_ch_q;
  logic [IDW-1:0]           sel_id_q;

  logic [NCH-1:0]           fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [NCH-1:0][IDW-1:0]  fifo_head;

  logic                     pick_vld;
  logic [CHW-1:0]           pick_ch;
  logic [CHW:0]             scan_ch;

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs. Stall comes from full alone, so a full FIFO refuses a
  // push even in the cycle it is being popped.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign fifo_push[c] = bus.i_mni_wb_ack_valid[c] && !fifo_full[c];
    assign fifo_pop[c]  = (state_q == ST_BC) && (sel_ch_q == CHW'(c));

    l2c_wb_ack_fifo #(
      .IDW   (IDW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .Clk       (Clk),
      .Reset     (Reset),
      .push_i    (fifo_push[c]),
      .push_id_i (bus.i_mni_wb_ack_id[c*IDW +: IDW]),
      .pop_i     (fifo_pop[c]),
      .head_o    (fifo_head[c]),
      .full_o    (fifo_full[c]),
      .empty_o   (fifo_empty[c])
    );
  end

  assign bus.o_mni_wb_ack_stall = fifo_full;
  assign bus.o_pending          = ~fifo_empty;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first non-empty channel at or after rr_q, wrapping at
  // NCH. scan_ch carries one extra bit so rr_q + i never overflows before the
  // wrap subtraction.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    scan_ch  = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_ch = {1'b0, rr_q} + (CHW+1)'(i);
      if (scan_ch >= (CHW+1)'(NCH)) scan_ch = scan_ch - (CHW+1)'(NCH);
      if (!pick_vld && !fifo_empty[scan_ch[CHW-1:0]]) begin
        pick_vld = 1'b1;
        pick_ch  = scan_ch[CHW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM. Channel and ID are latched on leaving Idle and held through
  // Tag and Broadcast, so the tag/broadcast buses come straight from flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      sel_ch_q <= '0;
      sel_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            sel_ch_q <= pick_ch;
            sel_id_q <= fifo_head[pick_ch];
            state_q  <= ST_TAG;
          end
        end
        ST_TAG: begin
          if (bus.i_tag_ack) state_q <= ST_BC;
        end
        ST_BC: begin
          rr_q    <= (sel_ch_q == CHW'(NCH-1)) ? '0 : sel_ch_q + CHW'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_tag_req      = (state_q == ST_TAG);
  assign bus.o_tag_id       = sel_id_q;
  assign bus.o_tag_ch       = sel_ch_q;
  assign bus.o_broadcast    = (state_q == ST_BC);
  assign bus.o_broadcast_id = sel_id_q;
  assign bus.o_broadcast_ch = sel_ch_q;

  // ---------------------------------------------------------------------------
  // Tag-wait watchdog. The counter sits at 0 outside Tag, so it reads k in the
  // k-th cycle after Tag entry; the flag is set as the count steps to TMO and
  // therefore rises exactly TMO cycles after entry. The counter saturates.
  // ---------------------------------------------------------------------------
`ifdef L2C_WB_ACK_TMO_EN
  localparam int TW0 = clog2(TMO + 1);
  localparam int TW  = (TW0 < 8) ? 8 : ((TW0 > 16) ? 16 : TW0);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_flag_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (state_q != ST_TAG)    tmo_cnt_q <= '0;
      else if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + TW'(1);
      if ((state_q == ST_TAG) && (tmo_cnt_q == TW'(TMO - 1))) tmo_flag_q <= 1'b1;
    end
  end

  assign bus.o_tag_timeout = tmo_flag_q;
`else
  assign bus.o_tag_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_l2c_wb_ack_mc.sv
// -----------------------------------------------------------------------------
// tb_l2c_wb_ack_mc
// Directed self-checking bench for l2c_wb_ack_mc (NCH=2, IDW=6, DEPTH=4,
// TMO=10). Cycle numbers in comments count clock edges from the cycle in
// which the first stimulus of each scenario is applied.
// -----------------------------------------------------------------------------
module tb_l2c_wb_ack_mc;

  localparam int NCH   = 2;
  localparam int IDW   = 6;
  localparam int DEPTH = 4;
  localparam int CHW   = 1;
  localparam int TMO   = 10;

`ifdef L2C_WB_ACK_TMO_EN
  localparam logic TMO_ON = 1'b1;
`else
  localparam logic TMO_ON = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] got_bc[$];   // {ch, id} of each observed broadcast
  int         got_cyc[$];
  int         nbc;

  always #5 Clk = ~Clk;

  l2c_wb_ack_mc_if #(.NCH(NCH), .IDW(IDW), .CHW(CHW)) bus ();

  l2c_wb_ack_mc #(
    .NCH(NCH), .IDW(IDW), .DEPTH(DEPTH), .CHW(CHW), .TMO(TMO)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset                  = 1'b1;
    bus.i_mni_wb_ack_valid = '0;
    bus.i_mni_wb_ack_id    = '0;
    bus.i_tag_ack          = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  // Records every broadcast over ncyc cycles; first_cyc labels the current cycle.
  task automatic collect(input int ncyc, input int first_cyc);
    got_bc.delete();
    got_cyc.delete();
    for (int k = 0; k < ncyc; k++) begin
      if (bus.o_broadcast) begin
        got_bc.push_back({bus.o_broadcast_ch, bus.o_broadcast_id});
        got_cyc.push_back(first_cyc + k);
      end
      step();
    end
  endtask

  initial begin
    logic [6:0] exp_rr [4];
    logic [6:0] exp_full [4];
    exp_rr   = '{{1'b0, 6'd1}, {1'b1, 6'd9}, {1'b0, 6'd2}, {1'b1, 6'd10}};
    exp_full = '{{1'b1, 6'h22}, {1'b1, 6'h23}, {1'b1, 6'h24}, {1'b1, 6'h25}};

    // ---------------- reset state ----------------
    do_reset();
    check("rst_tag_req", 32'(bus.o_tag_req), 32'd0);
    check("rst_bcast",   32'(bus.o_broadcast), 32'd0);
    check("rst_pending", 32'(bus.o_pending), 32'd0);
    check("rst_stall",   32'(bus.o_mni_wb_ack_stall), 32'd0);
    check("rst_tmo",     32'(bus.o_tag_timeout), 32'd0);

    // ---------------- spurious ack in Idle ----------------
    bus.i_tag_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("spur_tag_req", 32'(bus.o_tag_req), 32'd0);
      check("spur_bcast",   32'(bus.o_broadcast), 32'd0);
    end
    bus.i_tag_ack = 1'b0;

    // ---------------- single ack ----------------
    do_reset();
    bus.i_mni_wb_ack_valid = 2'b01;                 // c0
    bus.i_mni_wb_ack_id    = {6'h00, 6'h15};
    step();                                         // c1
    bus.i_mni_wb_ack_valid = 2'b00;
    check("s_pending_c1", 32'(bus.o_pending), 32'd1);
    check("s_req_c1",     32'(bus.o_tag_req), 32'd0);
    step();                                         // c2
    check("s_req_c2",     32'(bus.o_tag_req), 32'd1);
    check("s_tag_id",     32'(bus.o_tag_id), 32'h15);
    check("s_tag_ch",     32'(bus.o_tag_ch), 32'd0);
    step();                                         // c3
    check("s_req_c3",     32'(bus.o_tag_req), 32'd1);
    step();                                         // c4
    check("s_req_c4",     32'(bus.o_tag_req), 32'd1);
    check("s_bcast_c4",   32'(bus.o_broadcast), 32'd0);
    bus.i_tag_ack = 1'b1;
    step();                                         // c5
    bus.i_tag_ack = 1'b0;
    check("s_bcast_c5",   32'(bus.o_broadcast), 32'd1);
    check("s_bc_id",      32'(bus.o_broadcast_id), 32'h15);
    check("s_bc_ch",      32'(bus.o_broadcast_ch), 32'd0);
    check("s_req_c5",     32'(bus.o_tag_req), 32'd0);
    step();                                         // c6
    check("s_bcast_c6",   32'(bus.o_broadcast), 32'd0);
    check("s_pending_c6", 32'(bus.o_pending), 32'd0);

    // ---------------- round-robin ----------------
    do_reset();
    bus.i_mni_wb_ack_valid = 2'b11;                 // c0
    bus.i_mni_wb_ack_id    = {6'd9, 6'd1};
    step();                                         // c1
    bus.i_mni_wb_ack_id    = {6'd10, 6'd2};
    step();                                         // c2
    bus.i_mni_wb_ack_valid = 2'b00;
    bus.i_tag_ack          = 1'b1;
    collect(20, 2);
    bus.i_tag_ack          = 1'b0;
    check("rr_count", 32'(got_bc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_bc.size()) check($sformatf("rr_bc%0d", i), 32'(got_bc[i]), 32'(exp_rr[i]));
    end
    if (got_cyc.size() > 0) check("rr_first_cyc", 32'(got_cyc[0]), 32'd3);
    for (int i = 1; i < got_cyc.size(); i++)
      check($sformatf("rr_gap%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd3);

    // ---------------- full / stall ----------------
    do_reset();
    bus.i_mni_wb_ack_valid = 2'b10;                 // c0
    bus.i_mni_wb_ack_id    = {6'h21, 6'h00};
    step();                                         // c1
    bus.i_mni_wb_ack_id    = {6'h22, 6'h00};
    check("f_stall_c1", 32'(bus.o_mni_wb_ack_stall), 32'd0);
    step();                                         // c2
    bus.i_mni_wb_ack_id    = {6'h23, 6'h00};
    step();                                         // c3
    bus.i_mni_wb_ack_id    = {6'h24, 6'h00};
    check("f_stall_c3", 32'(bus.o_mni_wb_ack_stall), 32'd0);
    step();                                         // c4: 5th valid held
    bus.i_mni_wb_ack_id    = {6'h25, 6'h00};
    check("f_stall_c4",   32'(bus.o_mni_wb_ack_stall), 32'b10);
    check("f_pending_c4", 32'(bus.o_pending), 32'b10);
    check("f_tag_id",     32'(bus.o_tag_id), 32'h21);
    check("f_tag_ch",     32'(bus.o_tag_ch), 32'd1);
    step();                                         // c5
    step();                                         // c6
    check("f_stall_c6", 32'(bus.o_mni_wb_ack_stall), 32'b10);
    bus.i_tag_ack = 1'b1;
    step();                                         // c7: pop, push still stalled
    check("f_bcast_c7", 32'(bus.o_broadcast), 32'd1);
    check("f_bc_id_c7", 32'(bus.o_broadcast_id), 32'h21);
    check("f_stall_c7", 32'(bus.o_mni_wb_ack_stall), 32'b10);
    step();                                         // c8: 5th accepted here
    check("f_stall_c8", 32'(bus.o_mni_wb_ack_stall), 32'b00);
    step();                                         // c9
    bus.i_mni_wb_ack_valid = 2'b00;
    check("f_stall_c9", 32'(bus.o_mni_wb_ack_stall), 32'b10);
    collect(20, 9);
    bus.i_tag_ack = 1'b0;
    check("f_count", 32'(got_bc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_bc.size()) check($sformatf("f_bc%0d", i), 32'(got_bc[i]), 32'(exp_full[i]));
    end
    check("f_pending_end", 32'(bus.o_pending), 32'd0);

    // ---------------- reset mid-Tag ----------------
    do_reset();
    bus.i_mni_wb_ack_valid = 2'b01;                 // c0
    bus.i_mni_wb_ack_id    = {6'h00, 6'h31};
    step();                                         // c1
    bus.i_mni_wb_ack_id    = {6'h00, 6'h32};
    step();                                         // c2
    bus.i_mni_wb_ack_id    = {6'h00, 6'h33};
    step();                                         // c3
    bus.i_mni_wb_ack_valid = 2'b00;
    check("r_req_c3",     32'(bus.o_tag_req), 32'd1);
    check("r_tag_id_c3",  32'(bus.o_tag_id), 32'h31);
    check("r_pending_c3", 32'(bus.o_pending), 32'd1);
    Reset = 1'b1;
    step();                                         // c4
    check("r_req_c4",     32'(bus.o_tag_req), 32'd0);
    check("r_pending_c4", 32'(bus.o_pending), 32'd0);
    Reset         = 1'b0;
    bus.i_tag_ack = 1'b1;
    nbc = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.o_broadcast) nbc++;
    end
    bus.i_tag_ack = 1'b0;
    check("r_no_bcast",    32'(nbc), 32'd0);
    check("r_pending_end", 32'(bus.o_pending), 32'd0);

    // ---------------- tag-wait watchdog ----------------
    do_reset();
    bus.i_mni_wb_ack_valid = 2'b01;                 // c0
    bus.i_mni_wb_ack_id    = {6'h00, 6'h3A};
    step();                                         // c1
    bus.i_mni_wb_ack_valid = 2'b00;
    step();                                         // c2: Tag entry
    check("t_req_c2", 32'(bus.o_tag_req), 32'd1);
    for (int k = 0; k < 9; k++) step();             // c11
    check("t_tmo_c11", 32'(bus.o_tag_timeout), 32'd0);
    step();                                         // c12
    check("t_tmo_c12", 32'(bus.o_tag_timeout), 32'(TMO_ON));
    step(); step(); step();                         // c15
    check("t_tmo_c15", 32'(bus.o_tag_timeout), 32'(TMO_ON));
    check("t_req_c15", 32'(bus.o_tag_req), 32'd1);
    bus.i_tag_ack = 1'b1;
    step();                                         // c16
    bus.i_tag_ack = 1'b0;
    check("t_bcast",  32'(bus.o_broadcast), 32'd1);
    check("t_bc_id",  32'(bus.o_broadcast_id), 32'h3A);
    step();                                         // c17
    check("t_tmo_c17", 32'(bus.o_tag_timeout), 32'(TMO_ON));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
